// File: rtl/isa_pkg.sv
// Shared types and constants for the ISA single-mode DMA sequencer.
// The lane-fill helper replicates the low byte for 8-bit channel transfers.
package isa_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        XFER   = 3'd2,
        STROBE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic CH8     = 1'b0;
    localparam logic CH16    = 1'b1;
    localparam logic DIR_M2C = 1'b0;
    localparam logic DIR_C2M = 1'b1;

    function automatic logic [15:0] lane_fill(input logic ch, input logic [15:0] d);
        return (ch == CH8) ? {d[7:0], d[7:0]} : d;
    endfunction

endpackage

// File: rtl/isa_sync.sv
// Multi-stage synchroniser for one asynchronous ISA input.
// It presets to 1 so that active-low strobes read as inactive out of reset.
module isa_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // shift chain, oldest sample at the top bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/isa_dma_ctrl.sv
// ISA single-mode DMA sequencer for the sound core's 8-bit (DRQ1) and 16-bit (DRQ5) requesters.
// Round-robin arbitration, glitch-filtered strobes, registered bus-side and core-side outputs.
module isa_dma_ctrl
    import isa_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_STROBE  = 3,
    parameter logic [15:0] REQ_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req8,
    input  logic        req16,
    input  logic        dir8,
    input  logic        dir16,
    input  logic [15:0] wr_data,
    input  logic        IOR_N,
    input  logic        IOW_N,
    input  logic        DACK8_N,
    input  logic        DACK16_N,
    input  logic        TC,
    input  logic [15:0] sd_in,
    output logic        drq8,
    output logic        drq16,
    output logic        ack8,
    output logic        ack16,
    output logic [15:0] rd_data,
    output logic [15:0] sd_out,
    output logic        sd_oe,
    output logic        tc_seen,
    output logic        err_timeout
);

    localparam int               CNT_W    = $clog2(MIN_STROBE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_STROBE - 1);

    logic ior_s, iow_s, dack8_s, dack16_s, tc_s;
    logic dack_n_s, strobe_n_s, req_g_s, ack_s;

    state_t            state_q, state_d;
    logic              grant_q, grant_d, dir_q, dir_d, rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       tmo_q, tmo_d;
    logic              tc_q, tc_d, err_q, err_d;
    logic [15:0]       rd_data_q, rd_data_d, sd_out_q, sd_out_d;
    logic              sd_oe_q, sd_oe_d, drq8_q, drq8_d, drq16_q, drq16_d;
    logic              ack8_q, ack8_d, ack16_q, ack16_d, tc_seen_q, tc_seen_d;

    isa_sync #(.STAGES(SYNC_STAGES)) u_sync_ior   (.clk(clk), .reset(reset), .d_i(IOR_N),    .q_o(ior_s));
    isa_sync #(.STAGES(SYNC_STAGES)) u_sync_iow   (.clk(clk), .reset(reset), .d_i(IOW_N),    .q_o(iow_s));
    isa_sync #(.STAGES(SYNC_STAGES)) u_sync_dack8 (.clk(clk), .reset(reset), .d_i(DACK8_N),  .q_o(dack8_s));
    isa_sync #(.STAGES(SYNC_STAGES)) u_sync_dack16(.clk(clk), .reset(reset), .d_i(DACK16_N), .q_o(dack16_s));
    isa_sync #(.STAGES(SYNC_STAGES)) u_sync_tc    (.clk(clk), .reset(reset), .d_i(TC),       .q_o(tc_s));

    // only the granted channel's DACK/req and the direction's strobe are ever looked at
    always_comb begin
        dack_n_s   = (grant_q == CH8) ? dack8_s : dack16_s;
        req_g_s    = (grant_q == CH8) ? req8 : req16;
        strobe_n_s = (dir_q == DIR_M2C) ? iow_s : ior_s;
    end

    // next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        dir_d     = dir_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        tc_d      = tc_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        ack_s     = 1'b0;
        tc_seen_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                tmo_d = 16'd0;
                tc_d  = 1'b0;
                if (req8 && req16) begin
                    grant_d = rr_q;
                    rr_d    = ~rr_q;
                    state_d = REQ;
                end else if (req8) begin
                    grant_d = CH8;
                    state_d = REQ;
                end else if (req16) begin
                    grant_d = CH16;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
                if (state_d == REQ) begin
                    dir_d = (grant_d == CH8) ? dir8 : dir16;
                end else begin
                    dir_d = dir_q;
                end
            end
            REQ: begin
                if (!dack_n_s) begin
                    state_d = XFER;
                end else if (!req_g_s) begin
                    state_d = IDLE;
                end else if (tmo_q == REQ_TIMEOUT - 16'd1) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            XFER: begin
                tc_d = tc_q | tc_s;
                if (dack_n_s) begin
                    state_d = IDLE;
                end else if (!strobe_n_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STROBE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = {CNT_W{1'b0}};
                end
            end
            STROBE: begin
                tc_d = tc_q | tc_s;
                if (strobe_n_s) begin
                    state_d   = DONE;
                    ack_s     = 1'b1;
                    tc_seen_d = tc_q | tc_s;
                    rr_d      = ~grant_q;
                end else if (dir_q == DIR_M2C) begin
                    rd_data_d = lane_fill(grant_q, sd_in);
                end else begin
                    rd_data_d = rd_data_q;
                end
            end
            DONE: begin
                if (dack_n_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drq8_d   = ((state_d == REQ) || (state_d == XFER)) && (grant_d == CH8);
        drq16_d  = ((state_d == REQ) || (state_d == XFER)) && (grant_d == CH16);
        ack8_d   = ack_s && (grant_q == CH8);
        ack16_d  = ack_s && (grant_q == CH16);
        sd_oe_d  = (state_d == STROBE) && (dir_q == DIR_C2M);
        sd_out_d = sd_oe_d ? lane_fill(grant_q, wr_data) : sd_out_q;
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= CH8;
            dir_q     <= DIR_M2C;
            rr_q      <= CH8;
            cnt_q     <= {CNT_W{1'b0}};
            tmo_q     <= 16'd0;
            tc_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= 16'd0;
            sd_out_q  <= 16'd0;
            sd_oe_q   <= 1'b0;
            drq8_q    <= 1'b0;
            drq16_q   <= 1'b0;
            ack8_q    <= 1'b0;
            ack16_q   <= 1'b0;
            tc_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            dir_q     <= dir_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            tc_q      <= tc_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            sd_out_q  <= sd_out_d;
            sd_oe_q   <= sd_oe_d;
            drq8_q    <= drq8_d;
            drq16_q   <= drq16_d;
            ack8_q    <= ack8_d;
            ack16_q   <= ack16_d;
            tc_seen_q <= tc_seen_d;
        end
    end

    assign drq8        = drq8_q;
    assign drq16       = drq16_q;
    assign ack8        = ack8_q;
    assign ack16       = ack16_q;
    assign rd_data     = rd_data_q;
    assign sd_out      = sd_out_q;
    assign sd_oe       = sd_oe_q;
    assign tc_seen     = tc_seen_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_isa_dma_ctrl.sv
// Directed self-checking bench for isa_dma_ctrl with a scoreboard of expected acks.
// Sync depth 2 and glitch filter 3 give a drq drop 5 cycles after the strobe falls.
module tb_isa_dma_ctrl;

    localparam int SYNC = 2;
    localparam int MINS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req8 = 1'b0, req16 = 1'b0, dir8 = 1'b0, dir16 = 1'b0;
    logic [15:0] wr_data = 16'd0, sd_in = 16'd0;
    logic        IOR_N = 1'b1, IOW_N = 1'b1, DACK8_N = 1'b1, DACK16_N = 1'b1, TC = 1'b0;
    logic        drq8, drq16, ack8, ack16, sd_oe, tc_seen, err_timeout;
    logic [15:0] rd_data, sd_out;

    typedef struct packed {
        logic        ch;
        logic [15:0] rd;
        logic        tc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          ack_total = 0;
    int          both_drq = 0;
    int          tc_alone = 0;
    logic [15:0] exp_rd = 16'd0;

    isa_dma_ctrl #(.SYNC_STAGES(SYNC), .MIN_STROBE(MINS), .REQ_TIMEOUT(16'd100)) dut (
        .clk(clk), .reset(reset), .req8(req8), .req16(req16), .dir8(dir8), .dir16(dir16),
        .wr_data(wr_data), .IOR_N(IOR_N), .IOW_N(IOW_N), .DACK8_N(DACK8_N), .DACK16_N(DACK16_N),
        .TC(TC), .sd_in(sd_in), .drq8(drq8), .drq16(drq16), .ack8(ack8), .ack16(ack16),
        .rd_data(rd_data), .sd_out(sd_out), .sd_oe(sd_oe), .tc_seen(tc_seen),
        .err_timeout(err_timeout)
    );

    initial forever #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fill(input logic ch, input logic [15:0] d);
        return ch ? d : {d[7:0], d[7:0]};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_strobe(input logic dir, input logic v);
        if (dir) IOR_N = v;
        else     IOW_N = v;
    endtask

    task automatic wait_drq(input logic ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((ch ? drq16 : drq8) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
    endtask

    // one complete single-mode transfer on channel ch
    task automatic xfer(input string tag, input logic ch, input logic dir, input logic [15:0] sd,
                        input logic [15:0] wd, input int len, input int glitch,
                        input logic tc_on, input bit drop_req);
        bit   ok;
        int   drop_at, ack_at;
        logic oe_seen;
        if (ch) begin dir16 = dir; req16 = 1'b1; end
        else    begin dir8 = dir;  req8 = 1'b1;  end
        wait_drq(ch, ok);
        chk({tag, "_drq_up"}, ok, 1'b1);
        sd_in = sd;
        wr_data = wd;
        if (ch) DACK16_N = 1'b0;
        else    DACK8_N = 1'b0;
        cycles(3);
        oe_seen = 1'b0;
        if (glitch > 0) begin
            set_strobe(dir, 1'b0);
            cycles(glitch);
            set_strobe(dir, 1'b1);
            cycles(4);
            chk({tag, "_glitch_drq"}, ch ? drq16 : drq8, 1'b1);
            chk({tag, "_glitch_oe"}, sd_oe, 1'b0);
        end
        sb_q.push_back('{ch: ch, rd: (dir ? exp_rd : fill(ch, sd)), tc: tc_on});
        if (!dir) exp_rd = fill(ch, sd);
        set_strobe(dir, 1'b0);
        TC = tc_on;
        drop_at = 0;
        for (int i = 1; i <= len; i++) begin
            cycles(1);
            if (drop_at == 0 && (ch ? drq16 : drq8) === 1'b0) drop_at = i;
            if (sd_oe === 1'b1) oe_seen = 1'b1;
            if (i == SYNC + MINS && dir) begin
                chk({tag, "_oe_during"}, sd_oe, 1'b1);
                chk({tag, "_sd_out"}, sd_out, fill(ch, wd));
            end
        end
        chk({tag, "_drq_drop_at"}, drop_at, SYNC + MINS);
        if (!dir) chk({tag, "_oe_never"}, oe_seen, 1'b0);
        set_strobe(dir, 1'b1);
        TC = 1'b0;
        ack_at = 0;
        for (int i = 1; i <= 10; i++) begin
            cycles(1);
            if ((ch ? ack16 : ack8) === 1'b1) begin
                ack_at = i;
                break;
            end
        end
        chk({tag, "_ack_latency"}, ack_at, SYNC + 1);
        chk({tag, "_oe_after"}, sd_oe, 1'b0);
        if (ch) DACK16_N = 1'b1;
        else    DACK8_N = 1'b1;
        if (drop_req) begin
            req8 = 1'b0;
            req16 = 1'b0;
        end
        cycles(3);
    endtask

    // scoreboard: pops one expectation per ack pulse, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0) begin
            if (drq8 === 1'b1 && drq16 === 1'b1) both_drq++;
            if (ack8 === 1'b1 || ack16 === 1'b1) begin
                ack_total++;
                chk("ack_expected", (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("ack_channel", {ack16, ack8}, e.ch ? 2'b10 : 2'b01);
                    chk("rd_data", rd_data, e.rd);
                    chk("tc_seen", tc_seen, e.tc);
                end
            end else if (tc_seen === 1'b1) begin
                tc_alone++;
            end
        end
    end

    initial begin
        bit ok;
        int n;
        cycles(3);
        chk("rst_drq", {drq16, drq8}, 2'b00);
        chk("rst_ack", {ack16, ack8}, 2'b00);
        chk("rst_oe_tc_err", {sd_oe, tc_seen, err_timeout}, 3'b000);
        chk("rst_data", {rd_data, sd_out}, 32'd0);
        reset = 1'b0;
        cycles(2);

        xfer("t1_m2c8", 1'b0, 1'b0, 16'h00A5, 16'h0000, 8, 0, 1'b0, 1'b1);
        chk("t1_rd_a5a5", rd_data, 16'hA5A5);
        xfer("t2_c2m16", 1'b1, 1'b1, 16'h0000, 16'h1234, 10, 0, 1'b0, 1'b1);

        dir8 = 1'b0;
        dir16 = 1'b1;
        req8 = 1'b1;
        req16 = 1'b1;
        xfer("t3_rr0", 1'b0, 1'b0, 16'h0011, 16'h0000, 6, 0, 1'b0, 1'b0);
        xfer("t3_rr1", 1'b1, 1'b1, 16'h0000, 16'hABCD, 6, 0, 1'b0, 1'b0);
        xfer("t3_rr2", 1'b0, 1'b0, 16'hFF77, 16'h0000, 6, 0, 1'b0, 1'b0);
        xfer("t3_rr3", 1'b1, 1'b1, 16'h0000, 16'h5A5A, 6, 0, 1'b0, 1'b1);

        xfer("t4_glitch", 1'b0, 1'b0, 16'h003C, 16'h0000, 5, 2, 1'b0, 1'b1);
        xfer("t5_tc", 1'b0, 1'b1, 16'h0000, 16'h12BE, 6, 0, 1'b1, 1'b1);

        dir16 = 1'b1;
        req16 = 1'b1;
        wr_data = 16'h7777;
        wait_drq(1'b1, ok);
        chk("t6_drq_up", ok, 1'b1);
        DACK16_N = 1'b0;
        cycles(3);
        IOR_N = 1'b0;
        cycles(6);
        chk("t6_oe_before", sd_oe, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_oe_async", sd_oe, 1'b0);
        chk("t6_drq_async", drq16, 1'b0);
        chk("t6_ack_async", ack16, 1'b0);
        cycles(2);
        IOR_N = 1'b1;
        DACK16_N = 1'b1;
        req16 = 1'b0;
        exp_rd = 16'd0;
        reset = 1'b0;
        cycles(4);
        chk("t6_rd_cleared", rd_data, 16'd0);
        xfer("t7_after_rst", 1'b1, 1'b0, 16'hC3E1, 16'h0000, 7, 0, 1'b0, 1'b1);

        chk("t8_err_before", err_timeout, 1'b0);
        dir8 = 1'b0;
        req8 = 1'b1;
        wait_drq(1'b0, ok);
        chk("t8_drq_up", ok, 1'b1);
        n = 0;
        while (drq8 === 1'b1 && n < 200) begin
            cycles(1);
            n++;
        end
        req8 = 1'b0;
        chk("t8_timeout_cycles", n, 100);
        chk("t8_err_set", err_timeout, 1'b1);
        cycles(5);
        chk("t8_err_sticky", err_timeout, 1'b1);
        chk("t8_drq_idle", {drq16, drq8}, 2'b00);

        chk("end_sb_empty", sb_q.size(), 0);
        chk("end_ack_count", ack_total, 9);
        chk("end_no_dual_drq", both_drq, 0);
        chk("end_no_lone_tc", tc_alone, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
